prio_queue_ctrl: RTL



---
 rtl/prio_queue_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/prio_queue_ctrl.sv
// Serial frame receiver: hunts preamble/SFD, captures {src,dst,serv,data}, and feeds
// four per-priority FIFOs drained through a strict-priority valid/ready output register.
module prio_queue_ctrl #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PREAMBLE = 8'hAB,
  parameter logic [7:0] SFD      = 8'h28
) (
  input  logic        ser_clk,
  input  logic        reset_n,
  input  logic        ser_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  out_prio,
  output logic [7:0]  out_src,
  output logic [7:0]  out_dst,
  output logic [15:0] out_data,
  output logic [19:0] q_level,
  output logic [3:0]  q_full,
  output logic        drop_pulse,
  output logic [7:0]  drop_cnt,
  output logic        frame_err
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [4:0] LVL_MAX = 5'(DEPTH);

  typedef enum logic [1:0] {HUNT, SFD_CHK, CAPTURE, ENQ} state_t;

  state_t      state, state_nxt;
  logic [6:0]  sr;
  logic [7:0]  window;
  logic [5:0]  bitcnt, bitcnt_nxt;
  logic [39:0] cap;
  logic        enq;
  logic        frame_err_nxt;

  // Only the seven newest bits need storing; the eighth is the bit arriving this edge.
  assign window = {sr, ser_in};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      bitcnt    <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bitcnt    <= bitcnt_nxt;
      sr        <= window[6:0];
      frame_err <= frame_err_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    bitcnt_nxt    = bitcnt + 6'd1;
    frame_err_nxt = 1'b0;
    enq           = 1'b0;
    case (state)
      HUNT: begin
        bitcnt_nxt = '0;
        if (window == PREAMBLE) state_nxt = SFD_CHK;
      end
      SFD_CHK: begin
        if (bitcnt == 6'd7) begin
          bitcnt_nxt = '0;
          if (window == SFD) begin
            state_nxt = CAPTURE;
          end else begin
            state_nxt     = HUNT;
            frame_err_nxt = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (bitcnt == 6'd39) begin
          bitcnt_nxt = '0;
          state_nxt  = ENQ;
        end
      end
      ENQ: begin
        enq       = 1'b1;
        state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) cap <= '0;
    else if (state == CAPTURE) cap <= {cap[38:0], ser_in};
  end

  logic [7:0]    serv;
  logic [1:0]    tgt;
  logic [31:0]   mem [4][DEPTH];
  logic [PW-1:0] wr_ptr [4];
  logic [PW-1:0] rd_ptr [4];
  logic [4:0]    level [4];
  logic [3:0]    push, pop, nonempty;
  logic          drop, load, any_ne;
  logic [1:0]    sel;
  logic [31:0]   head;

  assign serv = cap[23:16];
  assign tgt  = (serv >= 8'd3) ? 2'd3 : serv[1:0];

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      q_full[i]   = (level[i] == LVL_MAX);
      nonempty[i] = (level[i] != 5'd0);
    end
    // Full test uses pre-edge levels: a pop on the same edge never makes room.
    drop      = enq && q_full[tgt];
    push[tgt] = enq && !q_full[tgt];
    if (nonempty[3])      sel = 2'd3;
    else if (nonempty[2]) sel = 2'd2;
    else if (nonempty[1]) sel = 2'd1;
    else                  sel = 2'd0;
    any_ne   = |nonempty;
    load     = !out_valid || out_ready;
    pop[sel] = load && any_ne;
  end

  assign head = mem[sel][rd_ptr[sel]];

  // NOTE: FIFO storage has no reset; pointers and levels alone decide which entries are live.
  always_ff @(posedge ser_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {cap[39:24], cap[15:0]};
    end
  end

  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      level[i] <= level[i] + 5'd1;
        else if (!push[i] && pop[i]) level[i] <= level[i] - 5'd1;
      end
    end
  end

  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_prio  <= '0;
      out_src   <= '0;
      out_dst   <= '0;
      out_data  <= '0;
    end else if (load) begin
      if (any_ne) begin
        out_valid <= 1'b1;
        out_prio  <= sel;
        out_src   <= head[31:24];
        out_dst   <= head[23:16];
        out_data  <= head[15:0];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ser_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign q_level = {level[3], level[2], level[1], level[0]};

endmodule
